rvga_mem_arbiter: RTL and testbench

//  Sits directly downstream of the core top: merges the icache and dcache DDR-side cacheline ports

---
 rtl/rvga_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_rvga_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvga_mem_arbiter.sv
// rvga_mem_arbiter: merges the icache and dcache cacheline ports onto a single
// DDR port. One line transaction in flight at a time, round-robin on contention,
// with a sticky watchdog flag for DDR transactions that never complete.
module rvga_mem_arbiter #(
  parameter int LINE_W      = 256,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  // icache side
  input  logic [ADDR_W-1:0] icache_iddr_addr,
  input  logic              icache_iddr_read,
  output logic [LINE_W-1:0] iddr_icache_rdata,
  output logic              iddr_icache_resp,
  // dcache side
  input  logic [ADDR_W-1:0] dcache_dddr_addr,
  input  logic              dcache_dddr_read,
  input  logic              dcache_dddr_write,
  input  logic [LINE_W-1:0] dcache_dddr_wdata,
  output logic [LINE_W-1:0] dddr_dcache_rdata,
  output logic              dddr_dcache_resp,
  // DDR side
  output logic [ADDR_W-1:0] ddr_addr,
  output logic              ddr_read,
  output logic              ddr_write,
  output logic [LINE_W-1:0] ddr_wdata,
  input  logic [LINE_W-1:0] ddr_rdata,
  input  logic              ddr_resp,
  // status
  output logic              err_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  // Counter is wide enough to hold TIMEOUT_CYC itself; it saturates there.
  localparam int                CNT_W     = $clog2(TIMEOUT_CYC + 1) + 1;
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

  state_t           state;
  logic             last_grant_d;
  logic             i_req;
  logic             d_req;
  logic             grant_i;
  logic             grant_d;
  logic             busy;
  logic [CNT_W-1:0] to_cnt;
  logic [CNT_W-1:0] to_cnt_inc;

  // Request decode and round-robin pick; I wins a tie when D was granted last.
  always_comb begin
    i_req      = icache_iddr_read;
    d_req      = dcache_dddr_read | dcache_dddr_write;
    grant_i    = i_req & (~d_req | last_grant_d);
    grant_d    = d_req & ~grant_i;
    busy       = (state != IDLE);
    to_cnt_inc = to_cnt + CNT_W'(1);
  end

  // Transaction FSM; DDR-side outputs are registers loaded at the grant edge
  // and cleared at the completion edge, so client input changes in BUSY have no effect.
  // last_grant only moves on a contested grant; an uncontested grant leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      ddr_addr     <= '0;
      ddr_read     <= 1'b0;
      ddr_write    <= 1'b0;
      ddr_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            state     <= BUSY_I;
            ddr_addr  <= icache_iddr_addr;
            ddr_read  <= 1'b1;
            ddr_write <= 1'b0;
            ddr_wdata <= '0;
            if (d_req) begin
              last_grant_d <= 1'b0;
            end
          end else if (grant_d) begin
            state     <= BUSY_D;
            ddr_addr  <= dcache_dddr_addr;
            ddr_read  <= ~dcache_dddr_write;
            ddr_write <= dcache_dddr_write;
            ddr_wdata <= dcache_dddr_write ? dcache_dddr_wdata : '0;
            if (i_req) begin
              last_grant_d <= 1'b1;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (ddr_resp) begin
            state     <= IDLE;
            ddr_addr  <= '0;
            ddr_read  <= 1'b0;
            ddr_write <= 1'b0;
            ddr_wdata <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          ddr_addr  <= '0;
          ddr_read  <= 1'b0;
          ddr_write <= 1'b0;
          ddr_wdata <= '0;
        end
      endcase
    end
  end

  // Watchdog: count BUSY cycles without a response; flag is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else if (!busy || ddr_resp) begin
      to_cnt <= '0;
    end else begin
      if (to_cnt != CNT_LIMIT) begin
        to_cnt <= to_cnt_inc;
      end
      if ((TIMEOUT_CYC != 0) && (to_cnt_inc == CNT_LIMIT)) begin
        err_timeout <= 1'b1;
      end
    end
  end

  // Response routing back to the granted client; the idle client sees zeros.
  always_comb begin
    iddr_icache_resp  = (state == BUSY_I) & ddr_resp;
    dddr_dcache_resp  = (state == BUSY_D) & ddr_resp;
    iddr_icache_rdata = iddr_icache_resp ? ddr_rdata : '0;
    dddr_dcache_rdata = dddr_dcache_resp ? ddr_rdata : '0;
  end

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// Self-checking bench for rvga_mem_arbiter with a transaction-level model of
// the round-robin arbitration and a randomised DDR responder.
module tb_rvga_mem_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] icache_iddr_addr;
  logic          icache_iddr_read;
  logic [LW-1:0] iddr_icache_rdata;
  logic          iddr_icache_resp;
  logic [AW-1:0] dcache_dddr_addr;
  logic          dcache_dddr_read;
  logic          dcache_dddr_write;
  logic [LW-1:0] dcache_dddr_wdata;
  logic [LW-1:0] dddr_dcache_rdata;
  logic          dddr_dcache_resp;
  logic [AW-1:0] ddr_addr;
  logic          ddr_read;
  logic          ddr_write;
  logic [LW-1:0] ddr_wdata;
  logic [LW-1:0] ddr_rdata;
  logic          ddr_resp;
  logic          err_timeout;

  int n_vec = 0;
  int n_err = 0;
  bit model_last_d;

  rvga_mem_arbiter #(.LINE_W(LW), .ADDR_W(AW), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .icache_iddr_addr(icache_iddr_addr), .icache_iddr_read(icache_iddr_read),
    .iddr_icache_rdata(iddr_icache_rdata), .iddr_icache_resp(iddr_icache_resp),
    .dcache_dddr_addr(dcache_dddr_addr), .dcache_dddr_read(dcache_dddr_read),
    .dcache_dddr_write(dcache_dddr_write), .dcache_dddr_wdata(dcache_dddr_wdata),
    .dddr_dcache_rdata(dddr_dcache_rdata), .dddr_dcache_resp(dddr_dcache_resp),
    .ddr_addr(ddr_addr), .ddr_read(ddr_read), .ddr_write(ddr_write),
    .ddr_wdata(ddr_wdata), .ddr_rdata(ddr_rdata), .ddr_resp(ddr_resp),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic clear_inputs();
    icache_iddr_addr  = '0;
    icache_iddr_read  = 1'b0;
    dcache_dddr_addr  = '0;
    dcache_dddr_read  = 1'b0;
    dcache_dddr_write = 1'b0;
    dcache_dddr_wdata = '0;
    ddr_rdata         = '0;
    ddr_resp          = 1'b0;
  endtask

  task automatic test_reset();
    logic [3*LW+AW+5:0] all_out;
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    all_out = {ddr_read, ddr_write, ddr_addr, ddr_wdata, iddr_icache_resp, iddr_icache_rdata,
               dddr_dcache_resp, dddr_dcache_rdata, err_timeout, 1'b0};
    n_vec++;
    if (all_out !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    @(negedge clk);
    rst = 1'b0;
    model_last_d = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({ddr_read, ddr_write, ddr_addr, err_timeout} !== '0) begin
      n_err++; $display("FAIL idle_after_reset: rd=%b wr=%b addr=%h err=%b want 0",
                        ddr_read, ddr_write, ddr_addr, err_timeout);
    end
  endtask

  task automatic test_i_read();
    logic [LW-1:0] line_a;
    line_a = rand_line();
    icache_iddr_addr = 32'h100;
    icache_iddr_read = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_vec++;
      if ({ddr_read, ddr_write, ddr_addr, ddr_wdata, iddr_icache_resp} !==
          {1'b1, 1'b0, 32'h100, {LW{1'b0}}, 1'b0}) begin
        n_err++; $display("FAIL i_busy c%0d: rd=%b wr=%b addr=%h resp=%b want rd=1 wr=0 addr=100 resp=0",
                          c, ddr_read, ddr_write, ddr_addr, iddr_icache_resp);
      end
    end
    @(negedge clk);
    ddr_rdata = line_a;
    ddr_resp  = 1'b1;
    #1;
    n_vec++;
    if ({iddr_icache_resp, iddr_icache_rdata, dddr_dcache_resp, dddr_dcache_rdata} !==
        {1'b1, line_a, 1'b0, {LW{1'b0}}}) begin
      n_err++; $display("FAIL i_resp: iresp=%b irdata=%h dresp=%b want iresp=1 irdata=%h dresp=0",
                        iddr_icache_resp, iddr_icache_rdata, dddr_dcache_resp, line_a);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    n_vec++;
    if ({ddr_read, ddr_write, ddr_addr, iddr_icache_resp} !== '0) begin
      n_err++; $display("FAIL i_after: rd=%b wr=%b addr=%h resp=%b want 0",
                        ddr_read, ddr_write, ddr_addr, iddr_icache_resp);
    end
  endtask

  task automatic test_d_write();
    logic [LW-1:0] line_b;
    line_b = rand_line();
    dcache_dddr_addr  = 32'h2000;
    dcache_dddr_write = 1'b1;
    dcache_dddr_wdata = line_b;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_vec++;
      if ({ddr_read, ddr_write, ddr_addr, ddr_wdata, dddr_dcache_resp} !==
          {1'b0, 1'b1, 32'h2000, line_b, 1'b0}) begin
        n_err++; $display("FAIL d_busy c%0d: rd=%b wr=%b addr=%h wdata=%h resp=%b want rd=0 wr=1 addr=2000 wdata=%h",
                          c, ddr_read, ddr_write, ddr_addr, ddr_wdata, dddr_dcache_resp, line_b);
      end
      if (c == 2) begin
        dcache_dddr_addr  = 32'h3000;
        dcache_dddr_wdata = rand_line();
      end
    end
    @(negedge clk);
    ddr_rdata = rand_line();
    ddr_resp  = 1'b1;
    #1;
    n_vec++;
    if ({dddr_dcache_resp, iddr_icache_resp, iddr_icache_rdata, ddr_addr} !==
        {1'b1, 1'b0, {LW{1'b0}}, 32'h2000}) begin
      n_err++; $display("FAIL d_resp: dresp=%b iresp=%b addr=%h want dresp=1 iresp=0 addr=2000",
                        dddr_dcache_resp, iddr_icache_resp, ddr_addr);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    n_vec++;
    if ({dddr_dcache_resp, ddr_read, ddr_write} !== 3'b000) begin
      n_err++; $display("FAIL d_single_pulse: dresp=%b rd=%b wr=%b want 0",
                        dddr_dcache_resp, ddr_read, ddr_write);
    end
  endtask

  task automatic test_stray_resp();
    @(negedge clk);
    ddr_rdata = rand_line();
    ddr_resp  = 1'b1;
    #1;
    n_vec++;
    if ({iddr_icache_resp, dddr_dcache_resp, iddr_icache_rdata, dddr_dcache_rdata} !== '0) begin
      n_err++; $display("FAIL stray_resp: iresp=%b dresp=%b want 0", iddr_icache_resp, dddr_dcache_resp);
    end
    @(negedge clk);
    clear_inputs();
    n_vec++;
    if ({ddr_read, ddr_write, iddr_icache_resp, dddr_dcache_resp} !== 4'b0000) begin
      n_err++; $display("FAIL stray_stays_idle: rd=%b wr=%b want 0", ddr_read, ddr_write);
    end
  endtask

  task automatic test_timeout_and_reset();
    @(negedge clk);
    icache_iddr_addr = $urandom;
    icache_iddr_read = 1'b1;
    // negedge j follows j-1 completed BUSY cycles; the flag rises after 8
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      n_vec++;
      if ({ddr_read, err_timeout} !== {1'b1, (j >= 9)}) begin
        n_err++; $display("FAIL timeout j%0d: rd=%b err=%b want rd=1 err=%b", j, ddr_read, err_timeout, (j >= 9));
      end
    end
    #2;
    ddr_rdata = rand_line();
    ddr_resp  = 1'b1;
    rst       = 1'b1;
    #1;
    n_vec++;
    if ({ddr_read, ddr_write, ddr_addr, ddr_wdata, err_timeout, iddr_icache_resp,
         iddr_icache_rdata, dddr_dcache_resp} !== '0) begin
      n_err++; $display("FAIL async_rst: rd=%b addr=%h err=%b iresp=%b want 0",
                        ddr_read, ddr_addr, err_timeout, iddr_icache_resp);
    end
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    model_last_d = 1'b1;
    #1;
    n_vec++;
    if ({ddr_read, err_timeout, iddr_icache_resp} !== 3'b000) begin
      n_err++; $display("FAIL post_rst: rd=%b err=%b iresp=%b want 0", ddr_read, err_timeout, iddr_icache_resp);
    end
  endtask

  // Transaction-level traffic: model decides the winner from pending flags
  // and the last contested winner; loser's request is held across the gap.
  task automatic test_traffic(input int n, input bit force_both);
    bit            ip, dp, win_d, d_wr;
    logic [AW-1:0] ia, da, exp_addr;
    logic [LW-1:0] dw, exp_wd, line;
    int            grants, lat, op;
    ip = 1'b0; dp = 1'b0; grants = 0;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      ddr_resp = 1'b0;
      if (!ip) begin
        ip = force_both | ($urandom_range(0, 1) == 1);
        ia = $urandom;
      end
      if (!dp) begin
        dp = force_both | ($urandom_range(0, 1) == 1);
        da = $urandom; dw = rand_line(); op = $urandom_range(0, 2);
        d_wr = (op != 0);
        dcache_dddr_read  = dp & (op != 1);
        dcache_dddr_write = dp & d_wr;
      end
      icache_iddr_read = ip; icache_iddr_addr = ia;
      dcache_dddr_addr = da; dcache_dddr_wdata = dw;
      #1;
      n_vec++;
      if ({ddr_read, ddr_write, iddr_icache_resp, dddr_dcache_resp, err_timeout} !== 5'b0) begin
        n_err++; $display("FAIL gap_idle t%0d: rd=%b wr=%b iresp=%b dresp=%b err=%b want 0",
                          t, ddr_read, ddr_write, iddr_icache_resp, dddr_dcache_resp, err_timeout);
      end
      if (!ip && !dp) continue;
      win_d = dp && (!ip || !model_last_d);
      if (ip && dp) model_last_d = win_d;
      if (force_both) begin
        n_vec++;
        if (win_d !== (grants % 2 == 1)) begin
          n_err++; $display("FAIL grant_order g%0d: model=%b want %b", grants, win_d, (grants % 2 == 1));
        end
      end
      grants++;
      exp_addr = win_d ? da : ia;
      exp_wd   = (win_d && d_wr) ? dw : '0;
      lat = $urandom_range(0, 4);
      for (int c = 0; c <= lat; c++) begin
        @(negedge clk);
        n_vec++;
        if ({ddr_read, ddr_write, ddr_addr, iddr_icache_resp, dddr_dcache_resp} !==
            {(win_d ? !d_wr : 1'b1), (win_d & d_wr), exp_addr, 2'b00}) begin
          n_err++; $display("FAIL traffic_busy t%0d: rd=%b wr=%b addr=%h want side_d=%b wr=%b addr=%h",
                            t, ddr_read, ddr_write, ddr_addr, win_d, d_wr, exp_addr);
        end
        if (!win_d || d_wr) begin
          n_vec++;
          if (ddr_wdata !== exp_wd) begin
            n_err++; $display("FAIL traffic_wdata t%0d: got %h want %h", t, ddr_wdata, exp_wd);
          end
        end
        if (win_d) begin
          dcache_dddr_addr = $urandom; dcache_dddr_wdata = rand_line();
        end else begin
          icache_iddr_addr = $urandom;
        end
      end
      @(negedge clk);
      line = rand_line();
      ddr_rdata = line;
      ddr_resp  = 1'b1;
      #1;
      n_vec++;
      if ({iddr_icache_resp, iddr_icache_rdata, dddr_dcache_resp, dddr_dcache_rdata} !==
          (win_d ? {1'b0, {LW{1'b0}}, 1'b1, line} : {1'b1, line, 1'b0, {LW{1'b0}}})) begin
        n_err++; $display("FAIL traffic_resp t%0d: iresp=%b dresp=%b side_d=%b irdata=%h drdata=%h want line %h",
                          t, iddr_icache_resp, dddr_dcache_resp, win_d, iddr_icache_rdata, dddr_dcache_rdata, line);
      end
      if (win_d) dp = 1'b0; else ip = 1'b0;
      icache_iddr_addr = ia; dcache_dddr_addr = da;
    end
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_stray_resp();
    test_timeout_and_reset();
    test_traffic(8, 1'b1);
    test_traffic(40, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
